reg_file_scoreboard: RTL and testbench

REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

---
 rtl/rf_pkg.sv | 23 ++
 rtl/rf_scoreboard.sv | 77 +++++++
 rtl/reg_file_scoreboard.sv | 148 ++++++++++++++
 tb/tb_reg_file_scoreboard.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register file with issue scoreboard.
//   RF_DATA_W   : default register width in bits
//   RF_NUM_REGS : default register count (power of two, >= 2)
//   RF_ADDR_W   : register index width for the default register count
//   wb_port_t   : one write-back port record (enable, destination, data).
//                 Its fields are sized for the default configuration; the top
//                 narrows them to its own ADDR_W/DATA_W on use.
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 16;
    localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);

    typedef struct packed {
        logic                 en;
        logic [RF_ADDR_W-1:0] dest;
        logic [RF_DATA_W-1:0] data;
    } wb_port_t;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// Pending-write tracker: one busy bit per architectural register plus a
// registered population count of the busy vector.
//   clk, rst              : clock, synchronous active-high reset
//   issue_en/issue_dest   : mark a destination as having a pending producer
//   clr0_en/clr0_dest     : write-back on port 0 retires its destination
//   clr1_en/clr1_dest     : write-back on port 1 retires its destination
//   flush                 : drop every pending flag
//   busy_vec              : registered busy flags
//   busy_count            : registered number of set busy flags (0..NUM_REGS)
// Update precedence per bit: reset > issue > flush > write-back clear > hold.
// -----------------------------------------------------------------------------
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_dest,
    input  logic                clr0_en,
    input  logic [ADDR_W-1:0]   clr0_dest,
    input  logic                clr1_en,
    input  logic [ADDR_W-1:0]   clr1_dest,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [ADDR_W:0]     busy_count
);

    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] busy_q;
    logic [ADDR_W:0]     count_d;
    logic [ADDR_W:0]     count_q;

    // Next busy vector: a new producer wins over flush and over a retiring write.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (issue_en && (issue_dest == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if (flush) begin
                busy_d[i] = 1'b0;
            end else if ((clr0_en && (clr0_dest == ADDR_W'(i))) ||
                         (clr1_en && (clr1_dest == ADDR_W'(i)))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
    end

    // Population count of the next vector so the registered count tracks busy_q.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            count_d = count_d + (ADDR_W + 1)'(busy_d[i]);
        end
    end

    // Busy state and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_vec   = busy_q;
    assign busy_count = count_q;

endmodule : rf_scoreboard

// File: rtl/reg_file_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_file_scoreboard
// Two-read / two-write register file with a pending-write scoreboard.
//   clk, rst                       : clock, synchronous active-high reset
//   src1, src2                     : read addresses
//   reg1, reg2                     : combinational read data
//   busy1, busy2                   : pending-write flags for src1/src2
//   wb0_en/wb0_dest/wb0_data       : write port 0
//   wb1_en/wb1_dest/wb1_data       : write port 1 (wins over port 0 on a
//                                    same-register collision)
//   issue_en/issue_dest            : mark destination pending
//   flush                          : clear all pending flags
//   busy_count                     : registered number of pending registers
// Optional build macro WB_BYPASS_EN: forwards same-cycle write-back data to
// the read ports (wb1 over wb0 over array) and hides the busy flag of a
// register being written this cycle. Without it the read ports show the
// pre-edge array contents and registered busy flags only.
// -----------------------------------------------------------------------------
module reg_file_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(NUM_REGS)-1:0]  src1,
    input  logic [$clog2(NUM_REGS)-1:0]  src2,
    output logic [DATA_W-1:0]            reg1,
    output logic [DATA_W-1:0]            reg2,
    output logic                         busy1,
    output logic                         busy2,
    input  logic                         wb0_en,
    input  logic [$clog2(NUM_REGS)-1:0]  wb0_dest,
    input  logic [DATA_W-1:0]            wb0_data,
    input  logic                         wb1_en,
    input  logic [$clog2(NUM_REGS)-1:0]  wb1_dest,
    input  logic [DATA_W-1:0]            wb1_data,
    input  logic                         issue_en,
    input  logic [$clog2(NUM_REGS)-1:0]  issue_dest,
    input  logic                         flush,
    output logic [$clog2(NUM_REGS):0]    busy_count
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    // Write-port records, index 1 is the higher-priority port.
    wb_port_t            wb_s [2];
    logic                wb_en_s   [2];
    logic [ADDR_W-1:0]   wb_dest_s [2];
    logic [DATA_W-1:0]   wb_data_s [2];

    logic [DATA_W-1:0]   mem_d [NUM_REGS];
    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_vec_s;

    assign wb_s[0] = '{en: wb0_en, dest: RF_ADDR_W'(wb0_dest), data: RF_DATA_W'(wb0_data)};
    assign wb_s[1] = '{en: wb1_en, dest: RF_ADDR_W'(wb1_dest), data: RF_DATA_W'(wb1_data)};

    // Narrow the package-sized records back to this instance's widths.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            wb_en_s[p]   = wb_s[p].en;
            wb_dest_s[p] = ADDR_W'(wb_s[p].dest);
            wb_data_s[p] = DATA_W'(wb_s[p].data);
        end
    end

    // Next array contents: port 1 overrides port 0 on the same register.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wb_en_s[1] && (wb_dest_s[1] == ADDR_W'(i))) begin
                mem_d[i] = wb_data_s[1];
            end else if (wb_en_s[0] && (wb_dest_s[0] == ADDR_W'(i))) begin
                mem_d[i] = wb_data_s[0];
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Register storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .issue_en   (issue_en),
        .issue_dest (issue_dest),
        .clr0_en    (wb_en_s[0]),
        .clr0_dest  (wb_dest_s[0]),
        .clr1_en    (wb_en_s[1]),
        .clr1_dest  (wb_dest_s[1]),
        .flush      (flush),
        .busy_vec   (busy_vec_s),
        .busy_count (busy_count)
    );

`ifdef WB_BYPASS_EN
    // Read port 1 with same-cycle write-back forwarding.
    always_comb begin
        if (wb_en_s[1] && (wb_dest_s[1] == src1)) begin
            reg1  = wb_data_s[1];
            busy1 = 1'b0;
        end else if (wb_en_s[0] && (wb_dest_s[0] == src1)) begin
            reg1  = wb_data_s[0];
            busy1 = 1'b0;
        end else begin
            reg1  = mem_q[src1];
            busy1 = busy_vec_s[src1];
        end
    end

    // Read port 2 with same-cycle write-back forwarding.
    always_comb begin
        if (wb_en_s[1] && (wb_dest_s[1] == src2)) begin
            reg2  = wb_data_s[1];
            busy2 = 1'b0;
        end else if (wb_en_s[0] && (wb_dest_s[0] == src2)) begin
            reg2  = wb_data_s[0];
            busy2 = 1'b0;
        end else begin
            reg2  = mem_q[src2];
            busy2 = busy_vec_s[src2];
        end
    end
`else
    // Plain read ports: pre-edge array contents and registered busy flags.
    always_comb begin
        reg1  = mem_q[src1];
        reg2  = mem_q[src2];
        busy1 = busy_vec_s[src1];
        busy2 = busy_vec_s[src2];
    end
`endif

endmodule : reg_file_scoreboard

// File: tb/tb_reg_file_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_file_scoreboard
// Directed scenarios followed by random traffic, compared against a simple
// array/bit-vector reference of the register file and its pending flags.
// -----------------------------------------------------------------------------
module tb_reg_file_scoreboard;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] src1, src2;
    logic [DW-1:0] reg1, reg2;
    logic          busy1, busy2;
    logic          wb0_en, wb1_en, issue_en, flush;
    logic [AW-1:0] wb0_dest, wb1_dest, issue_dest;
    logic [DW-1:0] wb0_data, wb1_data;
    logic [AW:0]   busy_count;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference state.
    logic [DW-1:0] m_regs [NR];
    bit            m_busy [NR];
    int            m_count;

    always #5 clk = ~clk;

    reg_file_scoreboard dut (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2),
        .reg1(reg1), .reg2(reg2), .busy1(busy1), .busy2(busy2),
        .wb0_en(wb0_en), .wb0_dest(wb0_dest), .wb0_data(wb0_data),
        .wb1_en(wb1_en), .wb1_dest(wb1_dest), .wb1_data(wb1_data),
        .issue_en(issue_en), .issue_dest(issue_dest), .flush(flush),
        .busy_count(busy_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the reference from the rules, then the DUT edge.
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wb0_en) m_regs[wb0_dest] = wb0_data;
            if (wb1_en) m_regs[wb1_dest] = wb1_data;
            if (flush) for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
            if (wb0_en) m_busy[wb0_dest] = 1'b0;
            if (wb1_en) m_busy[wb1_dest] = 1'b0;
            if (issue_en) m_busy[issue_dest] = 1'b1;
        end
        m_count = 0;
        for (int i = 0; i < NR; i++) m_count += int'(m_busy[i]);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; wb0_en = 1'b0; wb1_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
        wb0_dest = '0; wb1_dest = '0; issue_dest = '0;
        wb0_data = '0; wb1_data = '0;
    endtask

    // Expected read-port view for one address given the current inputs.
    task automatic exp_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic b);
        d = m_regs[a];
        b = m_busy[a];
`ifdef WB_BYPASS_EN
        if (wb1_en && wb1_dest == a) begin d = wb1_data; b = 1'b0; end
        else if (wb0_en && wb0_dest == a) begin d = wb0_data; b = 1'b0; end
`endif
    endtask

    task automatic check_model(input string tag);
        logic [DW-1:0] d1, d2;
        logic          b1, b2;
        exp_read(src1, d1, b1);
        exp_read(src2, d2, b2);
        check({tag, ".reg1"},  64'(reg1),  64'(d1));
        check({tag, ".reg2"},  64'(reg2),  64'(d2));
        check({tag, ".busy1"}, 64'(busy1), 64'(b1));
        check({tag, ".busy2"}, 64'(busy2), 64'(b2));
        check({tag, ".count"}, 64'(busy_count), 64'(m_count));
    endtask

    initial begin
        idle_inputs();
        src1 = '0; src2 = '0;
        m_count = 0;
        for (int i = 0; i < NR; i++) begin m_regs[i] = 'x; m_busy[i] = 1'b0; end

        // Reset for one cycle, then read two addresses.
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        src1 = 4'd3; src2 = 4'd15;
        #1;
        check("rst.reg1",  64'(reg1),  64'h0);
        check("rst.reg2",  64'(reg2),  64'h0);
        check("rst.busy1", 64'(busy1), 64'h0);
        check("rst.busy2", 64'(busy2), 64'h0);
        check("rst.count", 64'(busy_count), 64'h0);

        // Same-register write collision: port 1 data lands.
        wb0_en = 1'b1; wb0_dest = 4'd5; wb0_data = 32'hA5A5_0001;
        wb1_en = 1'b1; wb1_dest = 4'd5; wb1_data = 32'h0000_BEEF;
        tick();
        idle_inputs();
        src1 = 4'd5;
        #1;
        check("wb_prio.reg1", 64'(reg1), 64'h0000_BEEF);

        // Issue then retire register 7.
        issue_en = 1'b1; issue_dest = 4'd7;
        tick();
        idle_inputs();
        src1 = 4'd7;
        #1;
        check("issue7.busy1", 64'(busy1), 64'h1);
        check("issue7.count", 64'(busy_count), 64'h1);
        wb0_en = 1'b1; wb0_dest = 4'd7; wb0_data = 32'h0000_0077;
        tick();
        idle_inputs();
        #1;
        check("retire7.busy1", 64'(busy1), 64'h0);
        check("retire7.count", 64'(busy_count), 64'h0);

        // Issue and write-back to the same register: issue wins, data lands.
        issue_en = 1'b1; issue_dest = 4'd4;
        wb1_en = 1'b1; wb1_dest = 4'd4; wb1_data = 32'h0000_1234;
        tick();
        idle_inputs();
        src1 = 4'd4;
        #1;
        check("iss_wb4.busy1", 64'(busy1), 64'h1);
        check("iss_wb4.reg1",  64'(reg1),  64'h0000_1234);

        // Busy on 1, 2, 9 (4 still pending), then flush with issue to 2.
        issue_en = 1'b1; issue_dest = 4'd1; tick();
        issue_dest = 4'd2; tick();
        issue_dest = 4'd9; tick();
        idle_inputs();
        #1;
        check("pre_flush.count", 64'(busy_count), 64'd4);
        flush = 1'b1; issue_en = 1'b1; issue_dest = 4'd2;
        tick();
        idle_inputs();
        src1 = 4'd2; src2 = 4'd9;
        #1;
        check("flush.count", 64'(busy_count), 64'd1);
        check("flush.busy1", 64'(busy1), 64'h1);
        check("flush.busy2", 64'(busy2), 64'h0);

        // Same-cycle write-back visibility on a pending register 6.
        issue_en = 1'b1; issue_dest = 4'd6;
        tick();
        idle_inputs();
        src1 = 4'd6;
        wb0_en = 1'b1; wb0_dest = 4'd6; wb0_data = 32'hCAFE_F00D;
        #1;
`ifdef WB_BYPASS_EN
        check("bypass.reg1",  64'(reg1),  64'hCAFE_F00D);
        check("bypass.busy1", 64'(busy1), 64'h0);
`else
        check("nobypass.reg1",  64'(reg1),  64'h0);
        check("nobypass.busy1", 64'(busy1), 64'h1);
`endif
        tick();
        idle_inputs();
        #1;
        check("after_wb6.reg1",  64'(reg1),  64'hCAFE_F00D);
        check("after_wb6.busy1", 64'(busy1), 64'h0);

        // Reset beats write, issue and flush in the same cycle.
        rst = 1'b1; flush = 1'b1;
        issue_en = 1'b1; issue_dest = 4'd3;
        wb0_en = 1'b1; wb0_dest = 4'd6; wb0_data = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        src1 = 4'd6; src2 = 4'd3;
        #1;
        check("rst_prio.reg1",  64'(reg1),  64'h0);
        check("rst_prio.busy2", 64'(busy2), 64'h0);
        check("rst_prio.count", 64'(busy_count), 64'h0);

        // Random traffic against the reference.
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 59) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            issue_en   = $urandom_range(0, 1) == 1;
            issue_dest = AW'($urandom_range(0, NR - 1));
            wb0_en     = $urandom_range(0, 1) == 1;
            wb0_dest   = AW'($urandom_range(0, NR - 1));
            wb0_data   = $urandom;
            wb1_en     = $urandom_range(0, 1) == 1;
            wb1_dest   = ($urandom_range(0, 3) == 0) ? wb0_dest : AW'($urandom_range(0, NR - 1));
            wb1_data   = $urandom;
            if ($urandom_range(0, 3) == 0) issue_dest = wb0_dest;
            src1       = ($urandom_range(0, 2) == 0) ? wb1_dest : AW'($urandom_range(0, NR - 1));
            src2       = ($urandom_range(0, 2) == 0) ? wb0_dest : AW'($urandom_range(0, NR - 1));
            #1;
            check_model("rand");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule : tb_reg_file_scoreboard
